// File: rtl/alu_pkg.sv
// Shared constants and types for the operand stage and the ALU datapath around it.
package alu_pkg;

    localparam int DW = 16;  // datapath width
    localparam int RA = 4;   // register address width (16 registers)

    // ALU opcodes carried through to execute.
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_INC  = 3'b001,
        OP_CMP  = 3'b010,
        OP_LS   = 3'b011,
        OP_MOVB = 3'b100,
        OP_BNQ  = 3'b101
    } alu_op_e;

    // Control bits that travel with an instruction into the execute stage.
    typedef struct packed {
        logic [2:0] alu_ctrl;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
    } ex_ctrl_t;

endpackage

// File: rtl/operand_stage_if.sv
// Bundle of decode-side, forwarding-side and execute-side signals of the operand stage.
interface operand_stage_if #(
    parameter int DW = alu_pkg::DW,
    parameter int RA = alu_pkg::RA
);
    // decode handshake and decoded instruction
    logic          in_valid;
    logic          in_ready;
    logic [RA-1:0] rs1_addr;
    logic [RA-1:0] rs2_addr;
    logic [RA-1:0] rd_addr;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic [DW-1:0] imm;
    logic          use_imm;
    logic [2:0]    alu_ctrl;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          flush;

    // forwarding sources
    logic          exm_valid;
    logic          exm_reg_write;
    logic          exm_load;
    logic [RA-1:0] exm_rd;
    logic [DW-1:0] exm_data;
    logic          wb_valid;
    logic          wb_reg_write;
    logic [RA-1:0] wb_rd;
    logic [DW-1:0] wb_data;

    // execute handshake and operands
    logic          ex_valid;
    logic          ex_ready;
    logic [DW-1:0] ex_a;
    logic [DW-1:0] ex_b;
    logic [2:0]    ex_alu_ctrl;
    logic          ex_eq;
    logic [RA-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic [DW-1:0] ex_store_data;

    // surrounding pipeline: drives decode/forwarding/ex_ready, observes the stage outputs
    modport master (
        output in_valid, rs1_addr, rs2_addr, rd_addr, rs1_data, rs2_data, imm, use_imm,
               alu_ctrl, reg_write, mem_read, mem_write, flush,
               exm_valid, exm_reg_write, exm_load, exm_rd, exm_data,
               wb_valid, wb_reg_write, wb_rd, wb_data, ex_ready,
        input  in_ready, ex_valid, ex_a, ex_b, ex_alu_ctrl, ex_eq, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data
    );

    // operand stage itself
    modport slave (
        input  in_valid, rs1_addr, rs2_addr, rd_addr, rs1_data, rs2_data, imm, use_imm,
               alu_ctrl, reg_write, mem_read, mem_write, flush,
               exm_valid, exm_reg_write, exm_load, exm_rd, exm_data,
               wb_valid, wb_reg_write, wb_rd, wb_data, ex_ready,
        output in_ready, ex_valid, ex_a, ex_b, ex_alu_ctrl, ex_eq, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data
    );
endinterface

// File: rtl/fwd_mux.sv
// Forwarding mux for one source operand: EX/MEM result, then WB result, then register file.
module fwd_mux #(
    parameter int DW = alu_pkg::DW,
    parameter int RA = alu_pkg::RA
) (
    input  logic [RA-1:0] rs,
    input  logic [DW-1:0] rf_data,
    input  logic          exm_valid,
    input  logic          exm_reg_write,
    input  logic          exm_load,
    input  logic [RA-1:0] exm_rd,
    input  logic [DW-1:0] exm_data,
    input  logic          wb_valid,
    input  logic          wb_reg_write,
    input  logic [RA-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] data
);

    // A load in EX/MEM has no data yet; the hazard logic stalls for that case instead.
    logic exm_hit;
    logic wb_hit;

    assign exm_hit = exm_valid & exm_reg_write & ~exm_load & (exm_rd == rs);
    assign wb_hit  = wb_valid & wb_reg_write & (wb_rd == rs);

    // Priority select: the younger EX/MEM result shadows the older WB result.
    always_comb begin
        // NOTE: assigning a default first keeps every path covered so no latch is inferred.
        data = rf_data;
        if (exm_hit) begin
            data = exm_data;
        end else if (wb_hit) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/operand_stage.sv
// Operand stage: forwards source operands, detects load-use hazards and registers the
// instruction into the execute stage behind a valid/ready handshake.
module operand_stage
    import alu_pkg::*;
#(
    parameter int DW = alu_pkg::DW,
    parameter int RA = alu_pkg::RA
) (
    input  logic           clk,
    input  logic           rst_n,
    operand_stage_if.slave bus
);

    logic [DW-1:0] rs1_fwd;
    logic [DW-1:0] rs2_fwd;
    logic [DW-1:0] a_next;
    logic [DW-1:0] b_next;
    ex_ctrl_t      ctrl_next;

    logic          ex_valid_q;
    ex_ctrl_t      ctrl_q;
    logic [RA-1:0] rd_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] sd_q;
    logic          eq_q;

    logic rs1_pend;
    logic rs2_pend;
    logic rs2_used;
    logic hazard;
    logic advance;
    logic take;

    fwd_mux #(.DW(DW), .RA(RA)) u_fwd_rs1 (
        .rs            (bus.rs1_addr),
        .rf_data       (bus.rs1_data),
        .exm_valid     (bus.exm_valid),
        .exm_reg_write (bus.exm_reg_write),
        .exm_load      (bus.exm_load),
        .exm_rd        (bus.exm_rd),
        .exm_data      (bus.exm_data),
        .wb_valid      (bus.wb_valid),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd         (bus.wb_rd),
        .wb_data       (bus.wb_data),
        .data          (rs1_fwd)
    );

    fwd_mux #(.DW(DW), .RA(RA)) u_fwd_rs2 (
        .rs            (bus.rs2_addr),
        .rf_data       (bus.rs2_data),
        .exm_valid     (bus.exm_valid),
        .exm_reg_write (bus.exm_reg_write),
        .exm_load      (bus.exm_load),
        .exm_rd        (bus.exm_rd),
        .exm_data      (bus.exm_data),
        .wb_valid      (bus.wb_valid),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd         (bus.wb_rd),
        .wb_data       (bus.wb_data),
        .data          (rs2_fwd)
    );

    // A source waits while its producing load sits in our output register or in EX/MEM.
    assign rs1_pend = (ex_valid_q & ctrl_q.mem_read & (rd_q == bus.rs1_addr)) |
                      (bus.exm_valid & bus.exm_load & (bus.exm_rd == bus.rs1_addr));
    assign rs2_pend = (ex_valid_q & ctrl_q.mem_read & (rd_q == bus.rs2_addr)) |
                      (bus.exm_valid & bus.exm_load & (bus.exm_rd == bus.rs2_addr));
    assign rs2_used = ~bus.use_imm | bus.mem_write;
    assign hazard   = bus.in_valid & (rs1_pend | (rs2_used & rs2_pend));

    assign bus.in_ready = ~hazard & (~ex_valid_q | bus.ex_ready);

    // The register moves whenever its content is gone (or killed); it then takes either the
    // incoming instruction or a bubble. A flushed instruction is never taken.
    assign advance = bus.flush | ~ex_valid_q | bus.ex_ready;
    assign take    = ~bus.flush & bus.in_valid & bus.in_ready;

    // Operand selection for the instruction being accepted.
    always_comb begin
        a_next             = rs1_fwd;
        b_next             = bus.use_imm ? bus.imm : rs2_fwd;
        ctrl_next          = '0;
        ctrl_next.alu_ctrl  = bus.alu_ctrl;
        ctrl_next.reg_write = bus.reg_write;
        ctrl_next.mem_read  = bus.mem_read;
        ctrl_next.mem_write = bus.mem_write;
    end

    // Stage output register: load, bubble (everything zero) or hold under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ctrl_q     <= '0;
            rd_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sd_q       <= '0;
            eq_q       <= 1'b0;
        end else if (advance) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ex_valid_q <= take;
            ctrl_q     <= take ? ctrl_next : '0;
            rd_q       <= take ? bus.rd_addr : '0;
            a_q        <= take ? a_next : '0;
            b_q        <= take ? b_next : '0;
            sd_q       <= take ? rs2_fwd : '0;
            eq_q       <= take & (a_next == b_next);
        end
    end

    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_alu_ctrl   = ctrl_q.alu_ctrl;
    assign bus.ex_reg_write  = ctrl_q.reg_write;
    assign bus.ex_mem_read   = ctrl_q.mem_read;
    assign bus.ex_mem_write  = ctrl_q.mem_write;
    assign bus.ex_rd         = rd_q;
    assign bus.ex_a          = a_q;
    assign bus.ex_b          = b_q;
    assign bus.ex_store_data = sd_q;
    assign bus.ex_eq         = eq_q;

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed pipeline scenarios followed by random
// traffic compared against a rule-level reference model.
module tb_operand_stage;
    import alu_pkg::*;

    logic clk;
    logic rst_n;

    operand_stage_if bus ();

    operand_stage u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected contents of the stage output register.
    typedef struct packed {
        logic        v;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sd;
        logic        eq;
        logic [2:0]  op;
        logic [3:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } out_t;

    out_t exp_out;

    task automatic idle_inputs();
        bus.in_valid      = 1'b0;
        bus.rs1_addr      = '0;
        bus.rs2_addr      = '0;
        bus.rd_addr       = '0;
        bus.rs1_data      = '0;
        bus.rs2_data      = '0;
        bus.imm           = '0;
        bus.use_imm       = 1'b0;
        bus.alu_ctrl      = '0;
        bus.reg_write     = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.flush         = 1'b0;
        bus.exm_valid     = 1'b0;
        bus.exm_reg_write = 1'b0;
        bus.exm_load      = 1'b0;
        bus.exm_rd        = '0;
        bus.exm_data      = '0;
        bus.wb_valid      = 1'b0;
        bus.wb_reg_write  = 1'b0;
        bus.wb_rd         = '0;
        bus.wb_data       = '0;
        bus.ex_ready      = 1'b1;
    endtask

    task automatic drive(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                         input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] im,
                         input logic ui, input logic [2:0] op,
                         input logic rw, input logic mr, input logic mw);
        bus.in_valid  = 1'b1;
        bus.rs1_addr  = rs1;
        bus.rs2_addr  = rs2;
        bus.rd_addr   = rd;
        bus.rs1_data  = d1;
        bus.rs2_data  = d2;
        bus.imm       = im;
        bus.use_imm   = ui;
        bus.alu_ctrl  = op;
        bus.reg_write = rw;
        bus.mem_read  = mr;
        bus.mem_write = mw;
    endtask

    // ---------------- reference model (rule level) ----------------
    function automatic logic [15:0] fwd_ref(input logic [3:0] rs, input logic [15:0] rf);
        if (bus.exm_valid && bus.exm_reg_write && !bus.exm_load && bus.exm_rd == rs)
            return bus.exm_data;
        if (bus.wb_valid && bus.wb_reg_write && bus.wb_rd == rs)
            return bus.wb_data;
        return rf;
    endfunction

    function automatic bit load_pending(input logic [3:0] rs);
        bit in_ex  = exp_out.v && exp_out.mr && exp_out.rd == rs;
        bit in_exm = bus.exm_valid && bus.exm_load && bus.exm_rd == rs;
        return in_ex || in_exm;
    endfunction

    function automatic bit ref_hazard();
        bit rs2_counts = !bus.use_imm || bus.mem_write;
        if (!bus.in_valid) return 1'b0;
        return load_pending(bus.rs1_addr) || (rs2_counts && load_pending(bus.rs2_addr));
    endfunction

    function automatic out_t ref_issue();
        out_t o;
        o    = '0;
        o.v  = 1'b1;
        o.a  = fwd_ref(bus.rs1_addr, bus.rs1_data);
        o.sd = fwd_ref(bus.rs2_addr, bus.rs2_data);
        o.b  = bus.use_imm ? bus.imm : o.sd;
        o.eq = (o.a == o.b);
        o.op = bus.alu_ctrl;
        o.rd = bus.rd_addr;
        o.rw = bus.reg_write;
        o.mr = bus.mem_read;
        o.mw = bus.mem_write;
        return o;
    endfunction

    task automatic compare_outputs(input string tag);
        check({tag, "_valid"}, bus.ex_valid, exp_out.v);
        check({tag, "_a"}, bus.ex_a, exp_out.a);
        check({tag, "_b"}, bus.ex_b, exp_out.b);
        check({tag, "_sd"}, bus.ex_store_data, exp_out.sd);
        check({tag, "_eq"}, bus.ex_eq, exp_out.eq);
        check({tag, "_op"}, bus.ex_alu_ctrl, exp_out.op);
        check({tag, "_rd"}, bus.ex_rd, exp_out.rd);
        check({tag, "_rw"}, bus.ex_reg_write, exp_out.rw);
        check({tag, "_mr"}, bus.ex_mem_read, exp_out.mr);
        check({tag, "_mw"}, bus.ex_mem_write, exp_out.mw);
    endtask

    task automatic randomize_inputs();
        bus.in_valid      = ($urandom_range(0, 3) != 0);
        bus.rs1_addr      = 4'($urandom_range(0, 3));
        bus.rs2_addr      = 4'($urandom_range(0, 3));
        bus.rd_addr       = 4'($urandom_range(0, 3));
        bus.rs1_data      = 16'($urandom);
        bus.rs2_data      = ($urandom_range(0, 3) == 0) ? bus.rs1_data : 16'($urandom);
        bus.imm           = ($urandom_range(0, 3) == 0) ? bus.rs1_data : 16'($urandom);
        bus.use_imm       = 1'($urandom);
        bus.alu_ctrl      = 3'($urandom_range(0, 5));
        bus.reg_write     = 1'($urandom);
        bus.mem_read      = ($urandom_range(0, 2) == 0);
        bus.mem_write     = ($urandom_range(0, 3) == 0);
        bus.flush         = ($urandom_range(0, 15) == 0);
        bus.exm_valid     = 1'($urandom);
        bus.exm_reg_write = 1'($urandom);
        bus.exm_load      = ($urandom_range(0, 3) == 0);
        bus.exm_rd        = 4'($urandom_range(0, 3));
        bus.exm_data      = 16'($urandom);
        bus.wb_valid      = 1'($urandom);
        bus.wb_reg_write  = 1'($urandom);
        bus.wb_rd         = 4'($urandom_range(0, 3));
        bus.wb_data       = 16'($urandom);
        bus.ex_ready      = ($urandom_range(0, 9) < 7);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit hz;
        bit rdy;

        rst_n = 1'b0;
        idle_inputs();

        // reset state
        @(negedge clk);
        exp_out = '0;
        compare_outputs("reset");
        rst_n = 1'b1;

        // plain ADD, no forwarding
        @(negedge clk);
        drive(4'd1, 4'd2, 4'd5, 16'h0005, 16'h0003, 16'h0000, 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0);
        #1 check("add_in_ready", bus.in_ready, 1);
        @(negedge clk);
        check("add_valid", bus.ex_valid, 1);
        check("add_a", bus.ex_a, 16'h0005);
        check("add_b", bus.ex_b, 16'h0003);
        check("add_eq", bus.ex_eq, 0);

        // EX/MEM and WB both match rs1: EX/MEM wins
        bus.exm_valid = 1'b1; bus.exm_reg_write = 1'b1; bus.exm_rd = 4'd1; bus.exm_data = 16'h1234;
        bus.wb_valid  = 1'b1; bus.wb_reg_write  = 1'b1; bus.wb_rd  = 4'd1; bus.wb_data  = 16'hBEEF;
        #1 check("fwd_in_ready", bus.in_ready, 1);
        @(negedge clk);
        check("fwd_a", bus.ex_a, 16'h1234);
        check("fwd_b", bus.ex_b, 16'h0003);

        // load-use: LS r3, then ADD reads r3 -> two bubbles, then WB data forwarded
        idle_inputs();
        drive(4'd1, 4'd0, 4'd3, 16'h0100, 16'h0000, 16'h0004, 1'b1, OP_LS, 1'b1, 1'b1, 1'b0);
        #1 check("ld_in_ready", bus.in_ready, 1);
        @(negedge clk);
        check("ld_mr", bus.ex_mem_read, 1);
        check("ld_rd", bus.ex_rd, 3);
        drive(4'd3, 4'd2, 4'd4, 16'h0000, 16'h0003, 16'h0000, 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0);
        #1 check("lu1_in_ready", bus.in_ready, 0);
        @(negedge clk);
        check("bubble1_valid", bus.ex_valid, 0);
        check("bubble1_mr", bus.ex_mem_read, 0);
        check("bubble1_a", bus.ex_a, 0);
        bus.exm_valid = 1'b1; bus.exm_reg_write = 1'b1; bus.exm_load = 1'b1; bus.exm_rd = 4'd3;
        #1 check("lu2_in_ready", bus.in_ready, 0);
        @(negedge clk);
        check("bubble2_valid", bus.ex_valid, 0);
        check("bubble2_rw", bus.ex_reg_write, 0);
        bus.exm_valid = 1'b0; bus.exm_load = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_reg_write = 1'b1; bus.wb_rd = 4'd3; bus.wb_data = 16'h7777;
        #1 check("lu3_in_ready", bus.in_ready, 1);
        @(negedge clk);
        check("lu_issue_valid", bus.ex_valid, 1);
        check("lu_issue_a", bus.ex_a, 16'h7777);
        check("lu_issue_b", bus.ex_b, 16'h0003);

        // back-pressure: output held three cycles
        idle_inputs();
        bus.ex_ready = 1'b0;
        drive(4'd1, 4'd2, 4'd6, 16'h0011, 16'h0022, 16'h0000, 1'b0, OP_INC, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_in_ready", bus.in_ready, 0);
            @(negedge clk);
            check("stall_valid", bus.ex_valid, 1);
            check("stall_a", bus.ex_a, 16'h7777);
            check("stall_b", bus.ex_b, 16'h0003);
            check("stall_op", bus.ex_alu_ctrl, OP_ADD);
        end
        bus.ex_ready = 1'b1;
        #1 check("release_in_ready", bus.in_ready, 1);
        @(negedge clk);
        check("release_a", bus.ex_a, 16'h0011);
        check("release_b", bus.ex_b, 16'h0022);
        check("release_op", bus.ex_alu_ctrl, OP_INC);

        // flush during a load-use stall with back-pressure
        drive(4'd1, 4'd0, 4'd3, 16'h0100, 16'h0000, 16'h0004, 1'b1, OP_LS, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("fl_ld_mr", bus.ex_mem_read, 1);
        drive(4'd3, 4'd2, 4'd4, 16'h0000, 16'h0003, 16'h0000, 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0);
        bus.ex_ready = 1'b0;
        bus.flush    = 1'b1;
        #1 check("fl_hazard_in_ready", bus.in_ready, 0);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.ex_ready = 1'b1;
        check("fl_valid", bus.ex_valid, 0);
        check("fl_mr", bus.ex_mem_read, 0);
        check("fl_rw", bus.ex_reg_write, 0);
        #1 check("fl_in_ready", bus.in_ready, 1);
        @(negedge clk);
        check("fl_no_issue", bus.ex_valid, 0);

        // asynchronous reset mid-stall
        drive(4'd1, 4'd0, 4'd3, 16'h0055, 16'h0000, 16'h0004, 1'b1, OP_LS, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("rst_pre_valid", bus.ex_valid, 1);
        drive(4'd3, 4'd2, 4'd4, 16'h0000, 16'h0003, 16'h0000, 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0);
        #1 check("rst_pre_in_ready", bus.in_ready, 0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_valid", bus.ex_valid, 0);
        check("rst_async_a", bus.ex_a, 0);
        check("rst_async_mr", bus.ex_mem_read, 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        #1 check("rst_rel_in_ready", bus.in_ready, 1);

        // random traffic against the reference model
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_out = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            compare_outputs("rnd");
            randomize_inputs();
            #1;
            hz  = ref_hazard();
            rdy = !hz && (!exp_out.v || bus.ex_ready);
            check("rnd_in_ready", bus.in_ready, rdy);
            if (bus.flush)
                exp_out = '0;
            else if (bus.in_valid && rdy)
                exp_out = ref_issue();
            else if (!exp_out.v || bus.ex_ready)
                exp_out = '0;
        end
        @(negedge clk);
        compare_outputs("rnd_last");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameters: DW 16 (datapath width); RA 4 (register address width, 16 registers).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid / in_ready  in / out  1 / 1  decoded-instruction handshake from decode.
REQ-005 rs1_addr, rs2_addr, rd_addr  in  RA each  source and destination registers.
REQ-006 rs1_data, rs2_data  in  DW each  register-file read data.
REQ-007 imm  in  DW  immediate; use_imm  in  1  selects imm as operand B.
REQ-008 alu_ctrl  in  3  ALU opcode; reg_write, mem_read, mem_write  in  1 each  control bits.
REQ-009 flush  in  1  kill incoming and held instruction (taken branch).
REQ-010 exm_valid, exm_reg_write, exm_load  in  1 each; exm_rd  in  RA; exm_data  in  DW: EX/MEM forward source.
REQ-011 wb_valid, wb_reg_write  in  1 each; wb_rd  in  RA; wb_data  in  DW: writeback forward source.
REQ-012 ex_valid / ex_ready  out / in  1 / 1  handshake to execute stage.
REQ-013 ex_a, ex_b  out  DW each  ALU operands A and B.
REQ-014 ex_alu_ctrl  out  3; ex_eq  out  1 (A equals B after forwarding); ex_rd  out  RA; ex_reg_write, ex_mem_read, ex_mem_write  out  1 each.
REQ-015 ex_store_data  out  DW  forwarded rs2 value for stores.

Function
REQ-016 Output register loads when in_valid & in_ready; an output is held while ex_valid & ~ex_ready.
REQ-017 in_ready = ~hazard & (~ex_valid | ex_ready); latency one cycle from accept to ex_valid.
REQ-018 Forward per source: EX/MEM match (exm_valid & exm_reg_write & ~exm_load & exm_rd == rs) beats WB match (wb_valid & wb_reg_write & wb_rd == rs), which beats register-file data.
REQ-019 ex_a = forwarded rs1; ex_b = imm when use_imm, else forwarded rs2; ex_store_data = forwarded rs2 always.
REQ-020 ex_eq registered as (ex_a_next == ex_b_next), full DW compare.
REQ-021 hazard (load-use) = in_valid & source used & (held output is valid mem_read with ex_rd == rs, or exm_valid & exm_load & exm_rd == rs); rs2 counts as used only when ~use_imm or mem_write.
REQ-022 On hazard with ex_ready: insert bubble (ex_valid 0, all control bits 0); incoming instruction waits, in_ready 0.
REQ-023 Hazard clears after at most two bubbles; instruction then accepted with WB-forwarded load data.
REQ-024 flush: next cycle ex_valid 0 and control bits 0, in_ready 1; flush beats stall and hazard.
REQ-025 Simultaneous EX/MEM and WB match on same register: EX/MEM data wins.
REQ-026 Data outputs of bubbles are don't-care but driven 0.

Reset
REQ-027 rst_n low: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_eq 0; ex_a, ex_b, ex_store_data 0; ex_alu_ctrl 000; ex_rd 0; immediate effect.
REQ-028 Reset mid-stall discards the waiting instruction; in_ready 1 first cycle after release.

Structure
REQ-029 Shared alu_pkg holds DW, RA, opcode constants (ADD 000, INC 001, CMP 010, LS 011, MOVB 100, BNQ 101) and the ex-stage control struct.
REQ-030 One sub-module fwd_mux (one instance per source) computes forwarded value from rs address, rf data, EX/MEM and WB sources.

Verification
REQ-031 Accept ADD rs1=r1(0x0005), rs2=r2(0x0003), no forwards -> next cycle ex_valid 1, ex_a 0x0005, ex_b 0x0003, ex_eq 0.
REQ-032 Same with exm_rd=r1, exm_data 0x1234 and wb_rd=r1, wb_data 0xBEEF -> ex_a 0x1234.
REQ-033 LS load to r3 accepted, then ADD using r3 -> one bubble then second bubble while load in EX/MEM, then ADD issued with ex_a = wb_data.
REQ-034 ex_ready held 0 three cycles with valid output -> ex_a/ex_b/ex_alu_ctrl stable, in_ready 0; release -> next instruction issues.
REQ-035 flush asserted during load-use stall -> next cycle ex_valid 0, in_ready 1, no instruction issued.
REQ-036 rst_n low mid-operation (ex_valid 1) -> ex_valid 0, ex_a 0x0000 without clock edge.
